// File: rtl/fft_frame_ctrl.sv
// Purpose : frame sequencer around the iterative fft core; loads N samples, waits for
//           fft_finish under a watchdog, snapshots the result bus and drains it as a stream.
// Latency : load port follows each accepted sample by 1 cycle; DRAIN starts 1 cycle after fft_finish.
// Backpr. : s_ready/m_valid decode the registered state only; the source stalls outside LOAD,
//           and the drain holds each word until m_ready.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   enable, flush               frame start permission (level), synchronous abort (highest priority)
//   s_valid/s_ready/s_data      sample input stream
//   fft_data_in/addr/insert     registered load port into the core
//   fft_data_out, fft_finish    parallel result bus (word k at [MSB*k +: MSB]) and completion
//   m_valid/m_ready/m_data      result stream, with m_last on the final word and m_index = bin
//   busy, frame_done, timeout   status: not idle, end-of-frame pulse, watchdog-abort pulse
//
// Build option: define FFT_FRAME_CTRL_BITREV_EN to emit bins in bit-reversed buffer order
// (the core's natural frequency order); m_index then carries the reversed index.

module fft_frame_ctrl #(
    parameter int N       = 16,
    parameter int MSB     = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [MSB-1:0]         s_data,
    output logic [MSB-1:0]         fft_data_in,
    output logic [$clog2(N)-1:0]   fft_addr,
    output logic                   fft_insert_data,
    input  logic [MSB*N-1:0]       fft_data_out,
    input  logic                   fft_finish,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [MSB-1:0]         m_data,
    output logic                   m_last,
    output logic [$clog2(N)-1:0]   m_index,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout
);

    localparam int AW = $clog2(N);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_q,      state_d;
    logic [AW-1:0]     cnt_q,        cnt_d;        // load position
    logic [WW-1:0]     wcnt_q,       wcnt_d;       // watchdog cycles spent in WAIT
    logic [AW-1:0]     idx_q,        idx_d;        // drain position
    logic [MSB-1:0]    data_in_q,    data_in_d;
    logic [AW-1:0]     addr_q,       addr_d;
    logic              insert_q,     insert_d;
    logic              frame_done_q, frame_done_d;
    logic              timeout_q,    timeout_d;
    logic [MSB-1:0]    res_q [N];
    logic [MSB-1:0]    res_d [N];

    logic              s_hs;
    logic              m_hs;
    logic [AW-1:0]     sel_idx;

    // Handshakes only count in their own state; the ready/valid side is a pure state decode.
    assign s_hs = s_valid && (state_q == ST_LOAD);
    assign m_hs = m_ready && (state_q == ST_DRAIN);

`ifdef FFT_FRAME_CTRL_BITREV_EN
    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = v[AW-1-b];
        end
        return r;
    endfunction

    assign sel_idx = bit_rev(idx_q);
`else
    assign sel_idx = idx_q;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        idx_d        = idx_q;
        data_in_d    = data_in_q;
        addr_d       = addr_q;
        insert_d     = 1'b0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        res_d        = res_q;

        if (flush) begin
            // Abort wins over everything, including a handshake in the same cycle.
            state_d = ST_IDLE;
            cnt_d   = '0;
            wcnt_d  = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end
                end

                ST_LOAD: begin
                    // Address/data hold between samples; only the insert strobe drops.
                    if (s_hs) begin
                        data_in_d = s_data;
                        addr_d    = cnt_q;
                        insert_d  = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_WAIT;
                            cnt_d   = '0;
                            wcnt_d  = '0;
                        end
                    end
                end

                ST_WAIT: begin
                    // A finish in the watchdog's final cycle still completes the frame.
                    if (fft_finish) begin
                        for (int k = 0; k < N; k++) begin
                            res_d[k] = fft_data_out[MSB*k +: MSB];
                        end
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                        wcnt_d  = '0;
                    end else if (wcnt_q == WD_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        wcnt_d    = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (m_hs) begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            frame_done_d = 1'b1;
                            idx_d        = '0;
                            if (enable) begin
                                state_d = ST_LOAD;
                                cnt_d   = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            idx_q        <= '0;
            data_in_q    <= '0;
            addr_q       <= '0;
            insert_q     <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            res_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            idx_q        <= idx_d;
            data_in_q    <= data_in_d;
            addr_q       <= addr_d;
            insert_q     <= insert_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            res_q        <= res_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready         = (state_q == ST_LOAD);
    assign m_valid         = (state_q == ST_DRAIN);
    assign m_last          = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);
    assign m_index         = sel_idx;
    assign m_data          = res_q[sel_idx];
    assign busy            = (state_q != ST_IDLE);
    assign frame_done      = frame_done_q;
    assign timeout         = timeout_q;
    assign fft_data_in     = data_in_q;
    assign fft_addr        = addr_q;
    assign fft_insert_data = insert_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Purpose : self-checking bench for fft_frame_ctrl with a behavioural core/stream model.
// Latency : checks the load port one cycle after each accepted sample and DRAIN one cycle after finish.
// Backpr. : drives randomized s_valid gaps and m_ready stalls; outputs are sampled 1ns after posedge.

module tb_fft_frame_ctrl;

    localparam int N       = 16;
    localparam int MSB     = 16;
    localparam int TIMEOUT = 64;
    localparam int AW      = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 flush;
    logic                 s_valid;
    logic                 s_ready;
    logic [MSB-1:0]       s_data;
    logic [MSB-1:0]       fft_data_in;
    logic [AW-1:0]        fft_addr;
    logic                 fft_insert_data;
    logic [MSB*N-1:0]     fft_data_out;
    logic                 fft_finish;
    logic                 m_valid;
    logic                 m_ready;
    logic [MSB-1:0]       m_data;
    logic                 m_last;
    logic [AW-1:0]        m_index;
    logic                 busy;
    logic                 frame_done;
    logic                 timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [MSB-1:0] smp   [N];   // samples of the current frame
    logic [MSB-1:0] words [N];   // result words the core model presents on finish

    always #5 clk = ~clk;

    fft_frame_ctrl #(.N(N), .MSB(MSB), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .flush           (flush),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .fft_data_in     (fft_data_in),
        .fft_addr        (fft_addr),
        .fft_insert_data (fft_insert_data),
        .fft_data_out    (fft_data_out),
        .fft_finish      (fft_finish),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .m_index         (m_index),
        .busy            (busy),
        .frame_done      (frame_done),
        .timeout         (timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Emission order of bins: identity, or index reversed over AW bits.
    function automatic int exp_sel(input int i);
`ifdef FFT_FRAME_CTRL_BITREV_EN
        int r = 0;
        int v = i;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
`else
        return i;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_garbage();
        for (int k = 0; k < N; k++) fft_data_out[MSB*k +: MSB] = MSB'($urandom);
    endtask

    task automatic check_all_zero(input string pre);
        check_eq({pre, "_s_ready"},    s_ready, 0);
        check_eq({pre, "_insert"},     fft_insert_data, 0);
        check_eq({pre, "_m_valid"},    m_valid, 0);
        check_eq({pre, "_m_last"},     m_last, 0);
        check_eq({pre, "_busy"},       busy, 0);
        check_eq({pre, "_frame_done"}, frame_done, 0);
        check_eq({pre, "_timeout"},    timeout, 0);
        check_eq({pre, "_data_in"},    fft_data_in, 0);
        check_eq({pre, "_addr"},       fft_addr, 0);
        check_eq({pre, "_m_data"},     m_data, 0);
        check_eq({pre, "_m_index"},    m_index, 0);
    endtask

    // Push N samples; every accepted sample must appear on the load port the next cycle.
    task automatic load_frame(input bit dense, input bit fixed);
        int  k = 0;
        int  guard = 0;
        int  first_c = 0;
        int  last_c = 0;
        bit  hs;
        for (int i = 0; i < N; i++) smp[i] = fixed ? MSB'(i + 1) : MSB'($urandom);
        while (k < N && guard < 400) begin
            s_valid = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
            s_data  = s_valid ? smp[k] : MSB'($urandom);
            hs = s_valid && s_ready;
            step();
            guard++;
            if (hs) begin
                check_eq("ins_vld",  fft_insert_data, 1);
                check_eq("ins_addr", fft_addr, k);
                check_eq("ins_dat",  fft_data_in, smp[k]);
                if (k == 0) first_c = cyc;
                last_c = cyc;
                k++;
            end else begin
                check_eq("ins_gap", fft_insert_data, 0);
                if (k > 0) begin
                    check_eq("hold_addr", fft_addr, k - 1);
                    check_eq("hold_dat",  fft_data_in, smp[k-1]);
                end
            end
        end
        s_valid = 1'b0;
        check_eq("load_count", k, N);
        if (dense) check_eq("load_rate", last_c - first_c, N - 1);
        check_eq("load_end_rdy", s_ready, 0);
    endtask

    // Called right after the last sample was taken (state just entered WAIT);
    // the core model asserts finish so that it is sampled lat cycles after WAIT entry.
    task automatic finish_after(input int lat, input bit fixed);
        for (int k = 0; k < N; k++) words[k] = fixed ? MSB'(k * 'h0101) : MSB'($urandom);
        for (int t = 1; t < lat; t++) begin
            set_garbage();
            step();
            check_eq("wait_ins", fft_insert_data, 0);
        end
        check_eq("wait_rdy",  s_ready, 0);
        check_eq("wait_mvld", m_valid, 0);
        check_eq("wait_busy", busy, 1);
        for (int k = 0; k < N; k++) fft_data_out[MSB*k +: MSB] = words[k];
        fft_finish = 1'b1;
        step();
        fft_finish = 1'b0;
        set_garbage();
        check_eq("drain_start", m_valid, 1);
    endtask

    // mode 0: m_ready toggles 1,0; mode 1: random with stray finish pulses; else always ready.
    // stop_at < N returns with that many words accepted (DRAIN still active).
    task automatic drain_frame(input int mode, input int stop_at, input bit exp_busy);
        int j = 0;
        int guard = 0;
        int c = 0;
        bit hs;
        while (j < N && guard < 400) begin
            check_eq("m_vld",  m_valid, 1);
            check_eq("m_idx",  m_index, exp_sel(j));
            check_eq("m_dat",  m_data, words[exp_sel(j)]);
            check_eq("m_last", m_last, (j == N - 1));
            check_eq("m_fd",   frame_done, 0);
            if (j == stop_at) break;
            case (mode)
                0:       m_ready = (c % 2 == 0);
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            fft_finish = (mode == 1) && ($urandom_range(0, 5) == 0);
            if (fft_finish) set_garbage();
            hs = m_ready && m_valid;
            step();
            guard++;
            c++;
            if (hs) j++;
        end
        m_ready    = 1'b0;
        fft_finish = 1'b0;
        if (stop_at >= N) begin
            check_eq("drain_count", j, N);
            check_eq("done_pulse",  frame_done, 1);
            check_eq("post_mvld",   m_valid, 0);
            check_eq("post_busy",   busy, exp_busy);
            step();
            check_eq("done_clear",  frame_done, 0);
        end
    endtask

    initial begin
        int t;
        rst_n        = 1'b0;
        enable       = 1'b0;
        flush        = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        fft_data_out = '0;
        fft_finish   = 1'b0;
        m_ready      = 1'b0;

        #12;
        check_all_zero("rst");
        #10 rst_n = 1'b1;
        repeat (3) step();
        check_eq("idle_busy", busy, 0);
        check_eq("idle_rdy",  s_ready, 0);

        // Reset asserted mid-LOAD clears everything immediately.
        enable = 1'b1;
        step();
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = MSB'($urandom);
            step();
        end
        #2 rst_n = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        #1;
        check_all_zero("arst");
        #10 rst_n = 1'b1;
        repeat (3) step();
        check_eq("rel_busy", busy, 0);
        check_eq("rel_rdy",  s_ready, 0);

        // Directed frame: ramp samples, words k*0x0101 after 40 cycles, toggling m_ready.
        enable = 1'b1;
        load_frame(1'b1, 1'b1);
        finish_after(40, 1'b1);
        drain_frame(0, N, 1'b1);

        // Randomized back-to-back frames.
        for (int f = 0; f < 6; f++) begin
            load_frame(f[0], 1'b0);
            finish_after($urandom_range(1, 60), 1'b0);
            drain_frame(1, N, 1'b1);
        end

        // enable dropped mid-frame only takes effect after the frame ends.
        load_frame(1'b0, 1'b0);
        enable = 1'b0;
        finish_after($urandom_range(1, 30), 1'b0);
        drain_frame(2, N, 1'b0);

        // Watchdog: no finish; abort pulse exactly TIMEOUT cycles after WAIT entry.
        enable = 1'b1;
        load_frame(1'b1, 1'b0);
        enable = 1'b0;
        t = 0;
        while (t < TIMEOUT + 40) begin
            step();
            t++;
            if (timeout) break;
        end
        check_eq("wd_cycles", t, TIMEOUT);
        check_eq("wd_busy",   busy, 0);
        step();
        check_eq("wd_pulse",  timeout, 0);
        for (int k = 0; k < N; k++) fft_data_out[MSB*k +: MSB] = MSB'($urandom);
        fft_finish = 1'b1;
        step();
        fft_finish = 1'b0;
        check_eq("late_fin_mvld", m_valid, 0);
        check_eq("late_fin_busy", busy, 0);
        step();
        check_eq("late_fin_mvld2", m_valid, 0);

        // Flush in LOAD with a simultaneous sample: the sample is not taken.
        enable  = 1'b1;
        step();
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = MSB'($urandom);
            step();
        end
        flush = 1'b1;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        check_eq("flush_ld_ins",  fft_insert_data, 0);
        check_eq("flush_ld_rdy",  s_ready, 0);
        check_eq("flush_ld_busy", busy, 0);
        load_frame(1'b1, 1'b0);
        finish_after(10, 1'b0);

        // Flush during DRAIN at idx 5; the next frame restarts at address 0.
        drain_frame(2, 5, 1'b1);
        flush   = 1'b1;
        m_ready = 1'b1;
        step();
        flush   = 1'b0;
        m_ready = 1'b0;
        check_eq("flush_dr_mvld", m_valid, 0);
        check_eq("flush_dr_busy", busy, 0);
        check_eq("flush_dr_fd",   frame_done, 0);
        load_frame(1'b0, 1'b0);
        finish_after(5, 1'b0);
        drain_frame(1, N, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

endmodule
